// File: rtl/reg_file_if.sv
// Register-file port bundle: two read address/data pairs, one write port and the commit counter.
// Writes commit on the rising clk edge when reg_write=1 and write_reg!=0; reads are combinational with no handshake.
interface reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) ();
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              reg_write;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [15:0]       write_cnt;

    modport master (
        output read_reg1, read_reg2, write_reg, write_data, reg_write,
        input  read_data1, read_data2, write_cnt
    );

    modport slave (
        input  read_reg1, read_reg2, write_reg, write_data, reg_write,
        output read_data1, read_data2, write_cnt
    );
endinterface

// File: rtl/reg_file.sv
// MIPS integer register file: 2**ADDR_W x DATA_W, two combinational read ports, one clocked write port,
// r0 hardwired to zero, optional same-cycle write-to-read forwarding and a saturating commit counter.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    reg_file_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [15:0]       cnt;
    logic              commit;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    assign commit = bus.reg_write && (bus.write_reg != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[bus.write_reg] <= bus.write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (commit && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

    // Forwarding is suppressed in reset so both ports read zero while rst_n is low.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (bus.read_reg1 != '0) begin
            rd1 = regs[bus.read_reg1];
            if (BYPASS && rst_n && commit && (bus.write_reg == bus.read_reg1)) begin
                rd1 = bus.write_data;
            end
        end
        if (bus.read_reg2 != '0) begin
            rd2 = regs[bus.read_reg2];
            if (BYPASS && rst_n && commit && (bus.write_reg == bus.read_reg2)) begin
                rd2 = bus.write_data;
            end
        end
    end

    assign bus.read_data1 = rd1;
    assign bus.read_data2 = rd2;
    assign bus.write_cnt  = cnt;
endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: one forwarding and one non-forwarding instance driven identically,
// expected reads/count from an array model pushed per cycle and checked at the falling edge.
module tb_reg_file;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int EW = 4 * DW + 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    reg_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();
    reg_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus_nb ();

    reg_file #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    reg_file #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b0)) dut_nb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nb.slave)
    );

    // Reference model: plain array of architectural registers plus commit count.
    logic [DW-1:0] m_regs [32];
    int unsigned   m_cnt;

    logic [EW-1:0] exp_q [$];
    string         name_q [$];
    int            errors = 0;
    int            checks = 0;

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] ra, input bit byp, input bit we,
                                               input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        if (!rst_n || ra == 0) return '0;
        if (byp && we && wa != 0 && wa == ra) return wd;
        return m_regs[ra];
    endfunction

    task automatic cycle(input bit rst, input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] ra1, input logic [AW-1:0] ra2, input bit chk, input string name);
        @(posedge clk);
        #1;
        rst_n = rst;
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_cnt = 0;
        end
        bus_b.reg_write  = we;  bus_nb.reg_write  = we;
        bus_b.write_reg  = wa;  bus_nb.write_reg  = wa;
        bus_b.write_data = wd;  bus_nb.write_data = wd;
        bus_b.read_reg1  = ra1; bus_nb.read_reg1  = ra1;
        bus_b.read_reg2  = ra2; bus_nb.read_reg2  = ra2;
        if (chk) begin
            exp_q.push_back({model_rd(ra1, 1'b1, we, wa, wd), model_rd(ra2, 1'b1, we, wa, wd),
                             model_rd(ra1, 1'b0, we, wa, wd), model_rd(ra2, 1'b0, we, wa, wd),
                             16'(m_cnt)});
            name_q.push_back(name);
        end
        if (rst && we && wa != 0) begin
            m_regs[wa] = wd;
            if (m_cnt < 32'hFFFF) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check({n, "/byp_rd1"},   bus_b.read_data1,         e[EW-1 -: DW]);
            check({n, "/byp_rd2"},   bus_b.read_data2,         e[EW-1-DW -: DW]);
            check({n, "/nobyp_rd1"}, bus_nb.read_data1,        e[EW-1-2*DW -: DW]);
            check({n, "/nobyp_rd2"}, bus_nb.read_data2,        e[EW-1-3*DW -: DW]);
            check({n, "/byp_cnt"},   {16'd0, bus_b.write_cnt},  {16'd0, e[15:0]});
            check({n, "/nobyp_cnt"}, {16'd0, bus_nb.write_cnt}, {16'd0, e[15:0]});
        end
    end

    initial begin
        logic [AW-1:0] wa, ra1, ra2;
        bit we;
        bus_b.reg_write = 1'b0;  bus_nb.reg_write = 1'b0;
        bus_b.write_reg = '0;    bus_nb.write_reg = '0;
        bus_b.write_data = '0;   bus_nb.write_data = '0;
        bus_b.read_reg1 = '0;    bus_nb.read_reg1 = '0;
        bus_b.read_reg2 = '0;    bus_nb.read_reg2 = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_cnt = 0;

        cycle(1'b0, 1'b1, 5'd7, 32'h5555_5555, 5'd7, 5'd7, 1'b1, "in_reset");
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b1, "in_reset2");
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd1, 1'b1, "release");

        cycle(1'b1, 1'b1, 5'd8, 32'h1234_5678, 5'd0, 5'd0, 1'b1, "wr_r8");
        cycle(1'b1, 1'b1, 5'd9, 32'hFFFF_0000, 5'd8, 5'd0, 1'b1, "wr_r9");
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd9, 1'b1, "rd_r8_r9");

        cycle(1'b1, 1'b1, 5'd0, 32'hAAAA_AAAA, 5'd0, 5'd0, 1'b1, "wr_r0");
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, "rd_r0");

        cycle(1'b1, 1'b1, 5'd3, 32'd7, 5'd0, 5'd0, 1'b1, "wr_r3_7");
        cycle(1'b1, 1'b1, 5'd3, 32'd9, 5'd3, 5'd3, 1'b1, "bypass_r3");
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b1, "after_bypass");

        cycle(1'b1, 1'b0, 5'd4, 32'd1, 5'd4, 5'd4, 1'b1, "we_low");
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd4, 5'd3, 1'b1, "rd_r4");

        cycle(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b1, "wr_r5");
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd8, 1'b1, "rd_r5");
        cycle(1'b0, 1'b1, 5'd5, 32'h1111_1111, 5'd5, 5'd8, 1'b1, "async_reset");
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd9, 1'b1, "held_reset");
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd8, 1'b1, "after_reset");

        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom_range(0, 1));
            wa = ($urandom_range(0, 4) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            ra1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 7));
            ra2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
            cycle(1'b1, we, wa, $urandom, ra1, ra2, 1'b1, "random");
        end

        for (int i = 0; i < 65540; i++) begin
            cycle(1'b1, 1'b1, 5'd1, 32'(i) ^ 32'hC0DE_0000, 5'd1, 5'd2,
                  ((i % 8192) == 0) || (i >= 65530), "saturate");
        end
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd1, 1'b1, "sat_hold");
        cycle(1'b1, 1'b1, 5'd2, 32'h0BAD_F00D, 5'd2, 5'd1, 1'b1, "sat_more");
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd2, 5'd1, 1'b1, "sat_final");

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
